llc_dma_initiator: RTL

- DMA-side initiator for the LLC DMA request/response channel.
- Accepts one burst command (read or write, start line address, line count) from an accelerator/DMA engine.
- Issues one LLC DMA request per line with incrementing address; for reads, collects one response line per request and streams it back in order.
- Sits between the DMA engine and the LLC input arbiter, opposite the LLC's DMA request consumer and address/pending tracking.

---
 rtl/llc_dma_initiator_pkg.sv | 26 ++
 rtl/llc_dma_req_reg.sv | 54 +++++
 rtl/llc_dma_initiator.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/llc_dma_initiator_pkg.sv
// Shared types and constants for the LLC DMA initiator.
//   - default widths for line addresses, cache lines and burst lengths
//   - line_addr_t / line_t convenience types at the default widths
//   - DMA request direction encoding
//   - initiator FSM state enum
package llc_dma_initiator_pkg;

    localparam int unsigned DEF_LINE_ADDR_BITS  = 28;
    localparam int unsigned DEF_LINE_BITS       = 128;
    localparam int unsigned DEF_LEN_BITS        = 16;
    localparam int unsigned DEF_MAX_OUTSTANDING = 4;

    typedef logic [DEF_LINE_ADDR_BITS-1:0] line_addr_t;
    typedef logic [DEF_LINE_BITS-1:0]      line_t;

    localparam logic DMA_REQ_READ  = 1'b0;
    localparam logic DMA_REQ_WRITE = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StDone
    } init_state_e;

endpackage

// File: rtl/llc_dma_req_reg.sv
// One-entry valid/ready register holding a DMA request {write, addr, line}.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   in_valid/in_ready         load side; in_ready is high when empty or draining
//   in_write/in_addr/in_line  request fields to capture
//   out_valid/out_ready       drain side towards the LLC
//   out_write/out_addr/out_line  held request fields, stable while out_valid && !out_ready
module llc_dma_req_reg #(
    parameter int unsigned ADDR_BITS = 28,
    parameter int unsigned LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_write,
    input  logic [ADDR_BITS-1:0] in_addr,
    input  logic [LINE_BITS-1:0] in_line,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_write,
    output logic [ADDR_BITS-1:0] out_addr,
    output logic [LINE_BITS-1:0] out_line
);

    logic                 full_q;
    logic                 write_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [LINE_BITS-1:0] line_q;

    // Accepting while draining keeps one line per cycle through the register.
    assign in_ready  = !full_q || out_ready;
    assign out_valid = full_q;
    assign out_write = write_q;
    assign out_addr  = addr_q;
    assign out_line  = line_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            line_q  <= '0;
        end else if (in_valid && in_ready) begin
            full_q  <= 1'b1;
            write_q <= in_write;
            addr_q  <= in_addr;
            line_q  <= in_line;
        end else if (out_ready) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/llc_dma_initiator.sv
// DMA-side initiator for the LLC DMA request/response channel.
// Takes one burst command, issues one LLC request per line with incrementing
// address, and for reads streams the LLC responses back in order.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   cmd_*                          burst command (write flag, start line, line count)
//   wr_valid/wr_ready/wr_line      write data stream from the DMA engine
//   rd_valid/rd_ready/rd_line      read data stream to the DMA engine
//   llc_dma_req_*                  request channel to the LLC
//   llc_dma_rsp_*                  read response channel from the LLC
//   done                           one-cycle pulse at burst completion
//   busy                           high whenever a burst is in progress
module llc_dma_initiator
    import llc_dma_initiator_pkg::*;
#(
    parameter int unsigned LINE_ADDR_BITS  = DEF_LINE_ADDR_BITS,
    parameter int unsigned LINE_BITS       = DEF_LINE_BITS,
    parameter int unsigned LEN_BITS        = DEF_LEN_BITS,
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [LINE_ADDR_BITS-1:0] cmd_addr,
    input  logic [LEN_BITS-1:0]       cmd_len,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [LINE_BITS-1:0]      wr_line,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [LINE_BITS-1:0]      rd_line,
    output logic                      llc_dma_req_valid,
    input  logic                      llc_dma_req_ready,
    output logic                      llc_dma_req_write,
    output logic [LINE_ADDR_BITS-1:0] llc_dma_req_addr,
    output logic [LINE_BITS-1:0]      llc_dma_req_line,
    input  logic                      llc_dma_rsp_valid,
    output logic                      llc_dma_rsp_ready,
    input  logic [LINE_BITS-1:0]      llc_dma_rsp_line,
    output logic                      done,
    output logic                      busy
);

    localparam int unsigned OST_BITS = $clog2(MAX_OUTSTANDING) + 1;

    init_state_e               state_q;
    logic [LINE_ADDR_BITS-1:0] cur_addr_q;
    logic [LEN_BITS-1:0]       remaining_issue_q;
    logic [LEN_BITS-1:0]       remaining_rsp_q;
    logic [OST_BITS-1:0]       outstanding_q;

    logic                      in_wr;
    logic                      in_rd;
    logic                      rr_in_ready;
    logic                      rr_valid;
    logic                      rr_write;
    logic [LINE_ADDR_BITS-1:0] rr_addr;
    logic [LINE_BITS-1:0]      rr_line;
    logic                      wr_hs;
    logic                      rd_issue;
    logic                      req_hs;
    logic                      rsp_hs;
    logic                      rsp_ok;

    assign in_wr     = (state_q == StWr);
    assign in_rd     = (state_q == StRd);
    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

    assign wr_ready = in_wr && (remaining_issue_q != '0) && rr_in_ready;
    assign wr_hs    = wr_valid && wr_ready;

    llc_dma_req_reg #(
        .ADDR_BITS (LINE_ADDR_BITS),
        .LINE_BITS (LINE_BITS)
    ) u_req_reg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (wr_hs),
        .in_ready  (rr_in_ready),
        .in_write  (DMA_REQ_WRITE),
        .in_addr   (cur_addr_q),
        .in_line   (wr_line),
        .out_valid (rr_valid),
        .out_ready (llc_dma_req_ready),
        .out_write (rr_write),
        .out_addr  (rr_addr),
        .out_line  (rr_line)
    );

    // Read requests come straight from the address/counter registers.
    assign rd_issue = in_rd && (remaining_issue_q != '0) &&
                      (outstanding_q < OST_BITS'(MAX_OUTSTANDING));

    assign llc_dma_req_valid = in_wr ? rr_valid : rd_issue;
    assign llc_dma_req_write = in_wr ? rr_write : DMA_REQ_READ;
    assign llc_dma_req_addr  = in_wr ? rr_addr  : cur_addr_q;
    assign llc_dma_req_line  = in_wr ? rr_line  : '0;
    assign req_hs            = llc_dma_req_valid && llc_dma_req_ready;

    // Responses pass straight through; the consumer's ready is the LLC's ready.
    assign llc_dma_rsp_ready = in_rd && rd_ready;
    assign rd_valid          = in_rd && llc_dma_rsp_valid;
    assign rd_line           = llc_dma_rsp_line;
    assign rsp_hs            = llc_dma_rsp_valid && llc_dma_rsp_ready;
    // Stray responses (nothing outstanding) are forwarded but not counted.
    assign rsp_ok            = rsp_hs && (outstanding_q != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= StIdle;
            cur_addr_q        <= '0;
            remaining_issue_q <= '0;
            remaining_rsp_q   <= '0;
            outstanding_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        cur_addr_q        <= cmd_addr;
                        remaining_issue_q <= cmd_len;
                        remaining_rsp_q   <= cmd_len;
                        outstanding_q     <= '0;
                        if (cmd_len == '0) begin
                            state_q <= StDone;
                        end else begin
                            state_q <= cmd_write ? StWr : StRd;
                        end
                    end
                end
                StWr: begin
                    if (wr_hs) begin
                        cur_addr_q        <= cur_addr_q + LINE_ADDR_BITS'(1);
                        remaining_issue_q <= remaining_issue_q - LEN_BITS'(1);
                    end
                    // All lines loaded and the last one is leaving the register.
                    if (req_hs && (remaining_issue_q == '0)) begin
                        state_q <= StDone;
                    end
                end
                StRd: begin
                    if (req_hs) begin
                        cur_addr_q        <= cur_addr_q + LINE_ADDR_BITS'(1);
                        remaining_issue_q <= remaining_issue_q - LEN_BITS'(1);
                    end
                    if (req_hs && !rsp_ok) begin
                        outstanding_q <= outstanding_q + OST_BITS'(1);
                    end else if (!req_hs && rsp_ok) begin
                        outstanding_q <= outstanding_q - OST_BITS'(1);
                    end
                    if (rsp_ok) begin
                        remaining_rsp_q <= remaining_rsp_q - LEN_BITS'(1);
                        if (remaining_rsp_q == LEN_BITS'(1)) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // An LLC response with no read outstanding is a protocol error.
    assert property (@(posedge clk) disable iff (!rst) !(rsp_hs && (outstanding_q == '0)));

endmodule
